// File: rtl/alu_pkg.sv
// Shared ALU package: opcode constants for the 64-bit ALU and the
// state encoding of the iterative multiply/divide sequencer.
package alu_pkg;

    localparam int ALU_W = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative 64-bit unsigned multiply / restoring divide sequencer that
// borrows the shared ALU one operation per cycle while busy.
// Optional feature macro: MULDIV_EARLY_EXIT_EN (multiply stops as soon as
// the remaining multiplier is zero).
//
// Handshake: start is sampled only in IDLE; the accepting edge latches
// op/in_a/in_b. busy is high from the cycle after the accept through the
// DONE cycle. done is a one-cycle pulse; result_lo/result_hi/div_by_zero
// are valid from that cycle and held until the next accepted start.
// start while busy is ignored (no queueing).
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ALU_W-1:0]  in_a,
    input  logic [ALU_W-1:0]  in_b,
    output logic              busy,
    output logic              done,
    output logic [ALU_W-1:0]  result_lo,
    output logic [ALU_W-1:0]  result_hi,
    output logic              div_by_zero,
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic [3:0]        alu_op,
    input  logic [ALU_W-1:0]  alu_result,
    input  logic              alu_zero,
    input  logic              alu_gt,
    output state_t            dbg_state
);

    state_t            state;
    logic [6:0]        cnt;
    logic              op_r;
    // acc: multiply accumulator / divide remainder
    logic [ALU_W-1:0]  acc;
    // opa: multiplicand / dividend, both shift left each iteration
    logic [ALU_W-1:0]  opa;
    // opb: multiplier (shifts right) / divisor (held)
    logic [ALU_W-1:0]  opb;
    logic [ALU_W-1:0]  quo;

    logic [ALU_W-1:0]  rs;
    logic              cy;
    logic              take;
    logic [ALU_W-1:0]  rem_next;
    logic [ALU_W-1:0]  quo_next;
    logic              last_iter;

    // The carry out of the shifted remainder means rs >= 2^64 > divisor,
    // so the subtraction is always taken and the wrapped ALU result is exact.
    assign rs       = {acc[ALU_W-2:0], opa[ALU_W-1]};
    assign cy       = acc[ALU_W-1];
    assign take     = cy | alu_gt | alu_zero;
    assign rem_next = take ? alu_result : rs;
    assign quo_next = {quo[ALU_W-2:0], take};

`ifdef MULDIV_EARLY_EXIT_EN
    assign last_iter = (cnt == 7'd63) || (!op_r && (opb[ALU_W-1:1] == '0));
`else
    assign last_iter = (cnt == 7'd63);
`endif

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    // Drive the ALU operands only while iterating; neutral ADD 0+0 otherwise.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (state == ST_RUN) begin
            if (op_r) begin
                alu_op = ALU_SUB;
                alu_a  = rs;
                alu_b  = opb;
            end else begin
                alu_a = acc;
                alu_b = opb[0] ? opa : '0;
            end
        end
    end

    // Sequencer FSM with datapath registers and held results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_r        <= 1'b0;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            quo         <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        opa  <= in_a;
                        opb  <= in_b;
                        acc  <= '0;
                        quo  <= '0;
                        cnt  <= '0;
                        if (op && (in_b == '0)) begin
                            result_lo   <= '1;
                            result_hi   <= in_a;
                            div_by_zero <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 7'd1;
                    opa <= opa << 1;
                    if (op_r) begin
                        acc <= rem_next;
                        quo <= quo_next;
                    end else begin
                        acc <= alu_result;
                        opb <= opb >> 1;
                    end
                    if (last_iter) begin
                        result_lo   <= op_r ? quo_next : alu_result;
                        result_hi   <= op_r ? rem_next : '0;
                        div_by_zero <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural model of the
// shared ALU wired to the alu_* ports. Expected results come from native
// SystemVerilog arithmetic and are queued at drive time, popped on done.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        busy;
    logic        done;
    logic [63:0] result_lo;
    logic [63:0] result_hi;
    logic        div_by_zero;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        alu_gt;
    state_t      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // {div_by_zero, result_hi, result_lo}
    logic [128:0] exp_q[$];

    alu_muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .in_a        (in_a),
        .in_b        (in_b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_gt      (alu_gt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 64-bit ALU model
    always_comb begin
        case (alu_op)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            ALU_SLL: alu_result = alu_a << alu_b[5:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 64'd0);
        alu_gt   = (alu_a > alu_b);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [128:0] model(input logic o, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] lo;
        logic [63:0] hi;
        if (o && b == 64'd0) return {1'b1, a, 64'hFFFF_FFFF_FFFF_FFFF};
        if (o) begin
            lo = a / b;
            hi = a % b;
        end else begin
            lo = a * b;
            hi = 64'd0;
        end
        return {1'b0, hi, lo};
    endfunction

    // Cycles from the accept edge until done is observed.
    function automatic int exp_latency(input logic o, input logic [63:0] b);
        int msb;
        if (o && b == 64'd0) return 1;
        if (o) return 65;
`ifdef MULDIV_EARLY_EXIT_EN
        msb = 0;
        for (int i = 0; i < 64; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        msb = 0;
        return 65 + msb;
`endif
    endfunction

    // Scoreboard: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 129'(1), 129'(0));
            end else begin
                logic [128:0] e;
                e = exp_q.pop_front();
                check("result_lo",   129'(result_lo),   129'(e[63:0]));
                check("result_hi",   129'(result_hi),   129'(e[127:64]));
                check("div_by_zero", 129'(div_by_zero), 129'(e[128]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents start for one edge; returns at the negedge after the accept edge.
    task automatic start_op(input logic o, input logic [63:0] a, input logic [63:0] b, input bit push);
        @(negedge clk);
        op    = o;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        if (push) exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, checking latency and busy duration; optional re-pulse of start.
    task automatic wait_done(input string tag, input int exp_lat, input bit repulse);
        int c;
        int busy_cnt;
        c        = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && c < 300) begin
            @(negedge clk);
            c++;
            if (busy) busy_cnt++;
            if (repulse && c == 10) begin
                op    = 1'b1;
                in_a  = 64'h1234;
                in_b  = 64'h0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, 129'(c), 129'(exp_lat));
        check({tag, "_busy"}, 129'(busy_cnt), 129'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic o, input logic [63:0] a, input logic [63:0] b);
        start_op(o, a, b, 1'b1);
        wait_done(tag, exp_latency(o, b), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",   129'(busy),        129'(0));
        check("rst_done",   129'(done),        129'(0));
        check("rst_lo",     129'(result_lo),   129'(0));
        check("rst_hi",     129'(result_hi),   129'(0));
        check("rst_dbz",    129'(div_by_zero), 129'(0));
        check("rst_alu_op", 129'(alu_op),      129'(ALU_ADD));
        reset = 1'b1;

        // Directed operations
        run_op("mul_7x6",    1'b0, 64'd7, 64'd6);
        run_op("mul_wrap",   1'b0, 64'h8000_0000_0000_0000, 64'd2);
        run_op("div_100_7",  1'b1, 64'd100, 64'd7);
        run_op("div_cy",     1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
        run_op("div_zero",   1'b1, 64'd5, 64'd0);
        run_op("mul_b0",     1'b0, 64'd5, 64'd0);
        run_op("mul_5x3",    1'b0, 64'd5, 64'd3);
        run_op("div_eq",     1'b1, 64'd9, 64'd9);

        // ALU port driven with SUB while a divide iterates
        start_op(1'b1, 64'd1000, 64'd33, 1'b1);
        check("div_alu_op", 129'(alu_op), 129'(ALU_SUB));
        wait_done("div_1000_33", 65, 1'b0);

        // start re-pulsed mid-RUN is ignored
        start_op(1'b0, 64'd123456789, 64'd987654321, 1'b1);
        wait_done("mul_repulse", exp_latency(1'b0, 64'd987654321), 1'b1);
        repeat (3) @(negedge clk);
        check("repulse_idle", 129'(busy), 129'(0));

        // Reset at iteration 30 discards the operation
        start_op(1'b0, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        repeat (29) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 129'(busy),        129'(0));
        check("midrst_done", 129'(done),        129'(0));
        check("midrst_lo",   129'(result_lo),   129'(0));
        check("midrst_hi",   129'(result_hi),   129'(0));
        check("midrst_dbz",  129'(div_by_zero), 129'(0));
        reset = 1'b1;
        run_op("after_rst", 1'b1, 64'd77777, 64'd123);

        // Back-to-back: start held from the DONE cycle, accepted in first IDLE cycle
        start_op(1'b0, 64'd3, 64'd4, 1'b1);
        wait_done("b2b_first", exp_latency(1'b0, 64'd4), 1'b0);
        op    = 1'b1;
        in_a  = 64'd1_000_000;
        in_b  = 64'd999;
        start = 1'b1;
        exp_q.push_back(model(1'b1, 64'd1_000_000, 64'd999));
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (busy) start = 1'b0;
        end while (!done && gap < 300);
        check("b2b_cadence", 129'(gap), 129'(66));

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic        ro;
            logic [63:0] ra;
            logic [63:0] rb;
            ro = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'($urandom_range(0, 15));
                1:       rb = {32'd0, $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            run_op("rand", ro, ra, rb);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 129'(exp_q.size()), 129'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
